// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: register codes, FSM state encoding and the move-legality rule
// shared by the bus transfer controller.
package bus_xfer_pkg;
    typedef enum logic [3:0] {
        SRC_A, SRC_B, SRC_C, SRC_D, SRC_M1, SRC_M2, SRC_X, SRC_Y, SRC_MEM
    } src_e;
    typedef enum logic [3:0] {
        DST_A, DST_B, DST_C, DST_D, DST_M1, DST_M2, DST_X, DST_Y,
        DST_J1, DST_J2, DST_INST, DST_MEM, DST_CCR
    } dst_e;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SELECT  = 3'd1;
    localparam state_t ST_LOAD    = 3'd2;
    localparam state_t ST_RELEASE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;
    // A..Y share codes 0..7 on both sides, so src == dst there is a self-move.
    function automatic logic xfer_legal(input logic [3:0] src, input logic [3:0] dst);
        return src <= SRC_MEM && dst <= DST_CCR
            && !(src == dst && src <= SRC_Y)
            && !(src == SRC_MEM && dst == DST_MEM);
    endfunction
endpackage

// File: rtl/data_bus_xfer_ctrl_if.sv
// data_bus_xfer_ctrl_if: request handshake, shared-bus sample and strobe
// outputs of the transfer controller.
interface data_bus_xfer_ctrl_if #(parameter int DATA_BUS_WIDTH = 8);
    logic                      req_valid;
    logic                      req_ready;
    logic [3:0]                req_src;
    logic [3:0]                req_dst;
    logic [DATA_BUS_WIDTH-1:0] bus_data;
    logic [8:0]                drive_en;
    logic [12:0]               load_en;
    logic                      xfer_done;
    logic                      xfer_err;
    logic [DATA_BUS_WIDTH-1:0] xfer_data;
    modport master (
        output req_valid, req_src, req_dst, bus_data,
        input  req_ready, drive_en, load_en, xfer_done, xfer_err, xfer_data
    );
    modport slave (
        input  req_valid, req_src, req_dst, bus_data,
        output req_ready, drive_en, load_en, xfer_done, xfer_err, xfer_data
    );
endinterface

// File: rtl/xfer_phase_timer.sv
// xfer_phase_timer: 4-bit down-counter loaded on state entry; expire_o flags
// the last cycle of the current phase and the count saturates at zero.
module xfer_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       expire_o
);
    logic [3:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    assign expire_o = cnt_q == 4'd0;
endmodule

// File: rtl/data_bus_xfer_ctrl.sv
// data_bus_xfer_ctrl: sequences one register-to-register move over a shared
// bus: drive source, settle, strobe destination, hold, then report done.
module data_bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int LOAD_CYCLES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_bus_xfer_ctrl_if.slave  bus
);
    state_t                    state_q, state_d;
    logic [3:0]                src_q, src_d, dst_q, dst_d;
    logic                      err_q, err_d;
    logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
    logic                      hs, expire, tmr_load;
    logic [3:0]                tmr_val;
    assign hs = bus.req_valid && bus.req_ready;
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (hs && xfer_legal(bus.req_src, bus.req_dst)) state_d = ST_SELECT;
            ST_SELECT:  if (expire) state_d = ST_LOAD;
            ST_LOAD:    if (expire) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        src_d  = hs ? bus.req_src : src_q;
        dst_d  = hs ? bus.req_dst : dst_q;
        err_d  = hs && !xfer_legal(bus.req_src, bus.req_dst);
        data_d = (state_q == ST_LOAD && expire) ? bus.bus_data : data_q;
    end
    // Timer reloads on every state change with the length of the phase entered.
    assign tmr_load = state_d != state_q;
    assign tmr_val  = state_d == ST_SELECT ? 4'(SETTLE_CYCLES - 1)
                    : state_d == ST_LOAD   ? 4'(LOAD_CYCLES - 1) : 4'd0;
    xfer_phase_timer u_timer (
        .clk       (clk),
        .rst       (reset),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expire_o  (expire)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= 4'd0;
            dst_q   <= 4'd0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    // Ready is withheld during the error pulse so a rejection is one full beat.
    assign bus.req_ready = state_q == ST_IDLE && !err_q;
    assign bus.drive_en  = (state_q == ST_SELECT || state_q == ST_LOAD || state_q == ST_RELEASE)
                         ? 9'd1 << src_q : 9'd0;
    assign bus.load_en   = state_q == ST_LOAD ? 13'd1 << dst_q : 13'd0;
    assign bus.xfer_done = state_q == ST_DONE;
    assign bus.xfer_err  = err_q;
    assign bus.xfer_data = data_q;
    a_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.drive_en) && $onehot0(bus.load_en));
endmodule
